display_scheduler: RTL

Sequencing controller for the 8-digit multiplexed 7-segment display path. It divides the system clock into a one-cycle scan strobe that drives the multiplexer's `enable`. It also supplies the current digit index and runs a small animation state machine (static, scroll, blink) that tells the message/segment datapath which window offset to show and when to blank. It sits between the board-level control inputs and the character multiplexer, and is the only block that paces the display.

---
 rtl/display_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: paces the multiplexed 7-segment display.
// A free-running prescaler produces the scan strobe and digit index, and a
// small animation FSM (static / scroll / blink) drives offset and blank.
module display_scheduler #(
    parameter int SCAN_DIV    = 100000,
    parameter int STEP_DIV    = 250,
    parameter int NUM_DIGITS  = 8,
    parameter int MSG_LEN     = 5,
    parameter int BLINK_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       stop,
    output logic       scan_en,
    output logic [2:0] digit_idx,
    output logic [3:0] offset,
    output logic       blank,
    output logic       busy,
    output logic       done
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(STEP_DIV + 1);
    localparam int TW = $clog2(2 * BLINK_COUNT + 1);

    localparam logic [PW-1:0] PRE_LAST    = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_DIV - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(2 * BLINK_COUNT - 1);
    localparam logic [2:0]    DIGIT_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]    OFFSET_LAST = 4'(MSG_LEN + NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        STATIC,
        SCROLL,
        BLINK,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [SW-1:0]   step_q, step_d;
    logic [TW-1:0]   toggle_q, toggle_d;
    logic            scan_en_q, scan_en_d;
    logic [2:0]      digit_q, digit_d;
    logic [3:0]      offset_q, offset_d;
    logic            blank_q, blank_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            active;
    logic            accept;
    logic            step_tick;

    assign active    = (state_q == STATIC) || (state_q == SCROLL) || (state_q == BLINK);
    assign accept    = (state_q == IDLE) && start && (mode != 2'd3);
    assign step_tick = active && scan_en_q && (step_q == STEP_LAST);

    // Prescaler and digit scan run in every state, independent of the FSM.
    always_comb begin
        pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        scan_en_d = (pre_q == PRE_LAST);
        digit_d   = digit_q;
        if (scan_en_q) begin
            digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
        end
    end

    // Step counter: restarts with each accepted animation, counts strobes while active.
    always_comb begin
        step_d = step_q;
        if (accept) begin
            step_d = '0;
        end else if (active && scan_en_q) begin
            step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
        end
    end

    // Animation FSM: next state plus the registered offset/blank/busy/done values.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        blank_d  = blank_q;
        toggle_d = toggle_q;
        unique case (state_q)
            IDLE: begin
                offset_d = 4'd0;
                blank_d  = 1'b1;
                if (accept) begin
                    toggle_d = '0;
                    blank_d  = 1'b0;
                    unique case (mode)
                        2'd0:    state_d = STATIC;
                        2'd1:    state_d = SCROLL;
                        default: state_d = BLINK;
                    endcase
                end
            end
            STATIC: begin
                if (stop) begin
                    state_d = FINISH;
                    blank_d = 1'b1;
                end
            end
            SCROLL: begin
                if (stop) begin
                    state_d = FINISH;
                    blank_d = 1'b1;
                end else if (step_tick) begin
                    if (offset_q == OFFSET_LAST) begin
                        state_d = FINISH;
                        blank_d = 1'b1;
                    end else begin
                        offset_d = offset_q + 4'd1;
                    end
                end
            end
            BLINK: begin
                if (stop) begin
                    state_d = FINISH;
                    blank_d = 1'b1;
                end else if (step_tick) begin
                    toggle_d = toggle_q + 1'b1;
                    if (toggle_q == TOGGLE_LAST) begin
                        state_d = FINISH;
                        blank_d = 1'b1;
                    end else begin
                        blank_d = ~blank_q;
                    end
                end
            end
            FINISH: begin
                state_d  = IDLE;
                offset_d = 4'd0;
                blank_d  = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                offset_d = 4'd0;
                blank_d  = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            step_q    <= '0;
            toggle_q  <= '0;
            scan_en_q <= 1'b0;
            digit_q   <= 3'd0;
            offset_q  <= 4'd0;
            blank_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            step_q    <= step_d;
            toggle_q  <= toggle_d;
            scan_en_q <= scan_en_d;
            digit_q   <= digit_d;
            offset_q  <= offset_d;
            blank_q   <= blank_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign scan_en   = scan_en_q;
    assign digit_idx = digit_q;
    assign offset    = offset_q;
    assign blank     = blank_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
